// File: rtl/exp_4_2019a7ps0097h_pkg.sv
// Shared constants for the 3-bit parity generator/checker.
package exp_4_2019a7ps0097h_pkg;

    // Parity mode, driven straight from the D input.
    typedef enum logic {
        ParityEven = 1'b0,
        ParityOdd  = 1'b1
    } parity_mode_e;

    // Default error-counter width.
    localparam int unsigned ErrCntWDefault = 8;

endpackage

// File: rtl/exp_4_2019a7ps0097h_parity3_core.sv
// Combinational parity of a 3-bit word; odd mode inverts the even result.
module parity3_core
    import exp_4_2019a7ps0097h_pkg::*;
(
    input  logic [2:0]   data,
    input  parity_mode_e mode,
    output logic         parity
);

    // Parity bit that makes ones({data, parity}) even (ParityEven) or odd (ParityOdd).
    always_comb begin
        parity = (^data) ^ (mode == ParityOdd);
    end

endmodule

// File: rtl/exp_4_2019a7ps0097h.sv
// Registered 3-bit parity generator with optional check and saturating error counter.
module exp_4_2019a7ps0097h
    import exp_4_2019a7ps0097h_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = ErrCntWDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 A,
    input  logic                 B,
    input  logic                 C,
    input  logic                 D,
    input  logic                 in_valid,
    input  logic                 chk_en,
    input  logic                 chk_p,
    output logic                 P,
    output logic                 p_valid,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CntMax = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CntOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic                 gen_parity;
    logic                 p_d, p_q;
    logic                 p_valid_d, p_valid_q;
    logic                 err_d, err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    parity3_core u_parity (
        .data   ({A, B, C}),
        .mode   (parity_mode_e'(D)),
        .parity (gen_parity)
    );

    // Next-state: load parity on a valid word, flag mismatches, bump counter with saturation.
    always_comb begin
        p_d       = p_q;
        p_valid_d = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (in_valid) begin
            p_d       = gen_parity;
            p_valid_d = 1'b1;
            err_d     = chk_en && (chk_p != gen_parity);
        end
        // Counter advances in the same cycle err is raised, so both are seen together.
        if (err_d && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + CntOne;
        end
    end

    // State registers; asynchronous clear of all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= 1'b0;
            p_valid_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign P       = p_q;
    assign p_valid = p_valid_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_exp_4_2019a7ps0097h.sv
// Self-checking bench: default-width and 2-bit-counter instances share stimulus,
// both compared each cycle against a behavioural model.
module tb_exp_4_2019a7ps0097h;

    logic clk = 1'b0;
    logic rst_n;
    logic A, B, C, D, in_valid, chk_en, chk_p;

    logic       p_w, pv_w, err_w;
    logic [7:0] cnt_w;
    logic       p_s, pv_s, err_s;
    logic [1:0] cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic exp_p, exp_pv, exp_err;
    int   exp_cnt, exp_cnt_s;

    always #5 clk = ~clk;

    exp_4_2019a7ps0097h dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .in_valid (in_valid),
        .chk_en   (chk_en),
        .chk_p    (chk_p),
        .P        (p_w),
        .p_valid  (pv_w),
        .err      (err_w),
        .err_cnt  (cnt_w)
    );

    exp_4_2019a7ps0097h #(.ERR_CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .in_valid (in_valid),
        .chk_en   (chk_en),
        .chk_p    (chk_p),
        .P        (p_s),
        .p_valid  (pv_s),
        .err      (err_s),
        .err_cnt  (cnt_s)
    );

    logic [15:0] obs, exp_vec;
    assign obs = {p_w, pv_w, err_w, cnt_w, p_s, pv_s, err_s, cnt_s};

    always_comb begin
        exp_vec = {exp_p, exp_pv, exp_err, 8'(exp_cnt), exp_p, exp_pv, exp_err, 2'(exp_cnt_s)};
    end

    task automatic model_reset();
        exp_p = 1'b0; exp_pv = 1'b0; exp_err = 1'b0; exp_cnt = 0; exp_cnt_s = 0;
    endtask

    // Apply one cycle of stimulus, clock it, update the model, settle 1 time unit.
    task automatic drive(input logic [2:0] abc, input logic d, input logic v,
                         input logic ce, input logic cp);
        logic gp;
        {A, B, C} = abc; D = d; in_valid = v; chk_en = ce; chk_p = cp;
        @(posedge clk);
        gp = ((($countones(abc) + int'(d)) % 2) == 1);
        if (v) begin
            exp_p   = gp;
            exp_pv  = 1'b1;
            exp_err = ce && (cp != gp);
        end else begin
            exp_pv  = 1'b0;
            exp_err = 1'b0;
        end
        if (exp_err) begin
            exp_cnt   = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            exp_cnt_s = (exp_cnt_s == 3) ? 3 : exp_cnt_s + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        {A, B, C} = 3'b111; D = 1'b0; in_valid = 1'b1; chk_en = 1'b1; chk_p = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 16'h0) $display("FAIL reset_state got=%h want=%h", obs, 16'h0);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        // First word after release is processed normally.
        drive(3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== exp_vec || p_w !== 1'b1)
            $display("FAIL first_after_reset got=%h want=%h", obs, exp_vec);
        else n_pass++;
    endtask

    task automatic test_sweep(input logic d);
        logic [7:0] table_p;
        table_p = d ? 8'b01101001 : 8'b10010110; // bit i = expected P for word i
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), d, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec || p_w !== table_p[i] || pv_w !== 1'b1)
                $display("FAIL sweep_d%0d_w%0d got=%h want=%h P=%b tblP=%b",
                         d, i, obs, exp_vec, p_w, table_p[i]);
            else n_pass++;
        end
    endtask

    task automatic test_check();
        do_reset();
        drive(3'b101, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== exp_vec || err_w !== 1'b1 || cnt_w !== 8'd1)
            $display("FAIL check_mismatch got=%h want=%h err=%b cnt=%0d", obs, exp_vec, err_w, cnt_w);
        else n_pass++;
        drive(3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs !== exp_vec || err_w !== 1'b0 || cnt_w !== 8'd1)
            $display("FAIL check_match got=%h want=%h err=%b cnt=%0d", obs, exp_vec, err_w, cnt_w);
        else n_pass++;
        // chk_en low must never flag, even with a wrong chk_p.
        drive(3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== exp_vec) $display("FAIL check_disabled got=%h want=%h", obs, exp_vec);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'b011, 1'b1, 1'b1, 1'b1, 1'b0); // gp = 1, chk_p = 0
            n_checks++;
            if (obs !== exp_vec || err_s !== 1'b1 || cnt_s !== 2'((i + 1 > 3) ? 3 : i + 1))
                $display("FAIL saturate_%0d got=%h want=%h cnt_s=%0d", i, obs, exp_vec, cnt_s);
            else n_pass++;
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== exp_vec || cnt_s !== 2'd3 || err_s !== 1'b0)
            $display("FAIL saturate_hold got=%h want=%h", obs, exp_vec);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        drive(3'b111, 1'b0, 1'b1, 1'b1, 1'b0); // P = 1, another mismatch
        n_checks++;
        if (obs !== exp_vec || p_w !== 1'b1 || cnt_s !== 2'd3)
            $display("FAIL async_pre got=%h want=%h", obs, exp_vec);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 16'h0) $display("FAIL async_clear got=%h want=%h", obs, 16'h0);
        else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hold();
        drive(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== exp_vec || p_w !== 1'b1 || pv_w !== 1'b1)
            $display("FAIL hold_load got=%h want=%h", obs, exp_vec);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(3'($urandom_range(7)), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            n_checks++;
            if (obs !== exp_vec || p_w !== 1'b1 || pv_w !== 1'b0)
                $display("FAIL hold_%0d got=%h want=%h", i, obs, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(7)), 1'($urandom), ($urandom_range(3) != 0),
                  1'($urandom), 1'($urandom));
            n_checks++;
            if (obs !== exp_vec) $display("FAIL random_%0d got=%h want=%h", i, obs, exp_vec);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_check();
        test_saturation();
        test_async_reset();
        test_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exp_4_2019a7ps0097h.md
EXP_4_2019A7PS0097H -- requirements
Module: exp_4_2019a7ps0097h

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset ports SHALL be named clk and rst_n.
REQ-002 Parameter ERR_CNT_W, default 8, SHALL set the error-counter width in bits (legal range 2..16).
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Ports A, B, C, input, 1 bit each, SHALL be the 3-bit data word (A = MSB).
REQ-006 Port D, input, 1 bit, SHALL select parity mode: 0 = even, 1 = odd.
REQ-007 Port in_valid, input, 1 bit, SHALL qualify A/B/C/D (and chk_en/chk_p) for one cycle.
REQ-008 Port chk_en, input, 1 bit, SHALL request check mode, in which chk_p is compared rather than only generating.
REQ-009 Port chk_p, input, 1 bit, SHALL be the received parity bit to check.
REQ-010 Port P, output, 1 bit, SHALL be the registered generated parity bit.
REQ-011 Port p_valid, output, 1 bit, SHALL pulse high for one cycle when P is updated.
REQ-012 Port err, output, 1 bit, SHALL pulse high for one cycle on a detected parity mismatch.
REQ-013 Port err_cnt, output, ERR_CNT_W bits, SHALL count detected mismatches.

Function
REQ-014 Generated parity SHALL be A xor B xor C xor D: even mode makes the ones-count of {A,B,C,P} even; odd mode makes it odd.
REQ-015 When in_valid = 1 at a rising edge, P SHALL load the generated parity and p_valid SHALL be 1 on the following cycle (latency 1).
REQ-016 When in_valid = 0, P SHALL hold its value and p_valid SHALL be 0.
REQ-017 When in_valid = 1 and chk_en = 1, err SHALL be 1 on the next cycle if chk_p differs from the generated parity, and 0 otherwise.
REQ-018 When chk_en = 0 or in_valid = 0, err SHALL be 0 on the next cycle.
REQ-019 err_cnt SHALL increment by 1 on each cycle in which err is asserted and SHALL saturate at all-ones (no wrap).
REQ-020 Back-to-back in_valid cycles SHALL each produce an independent result with no bubble.
REQ-021 The outputs SHALL contain no combinational path from inputs; all outputs SHALL be registered.

Reset
REQ-022 While rst_n = 0, P, p_valid, err and err_cnt SHALL be 0 immediately, independent of clk.
REQ-023 On deassertion of rst_n, the first in_valid sampled SHALL be processed normally; an in_valid coincident with assertion of reset SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL clear err_cnt even if it is saturated.

Structure
REQ-025 The mode encodings (EVEN = 0, ODD = 1) and the default ERR_CNT_W SHALL be defined as constants in a shared package.
REQ-026 Parity computation SHALL be a single combinational sub-module named parity3_core (inputs: data[2:0], mode; output: parity), instantiated once.

Verification
REQ-027 The bench SHALL cover an even-mode sweep: A,B,C over 000..111 with D = 0 -> P = 0,1,1,0,1,0,0,1, each one cycle after in_valid, with p_valid = 1 each cycle.
REQ-028 The bench SHALL cover an odd-mode sweep: the same words with D = 1 -> P = 1,0,0,1,0,1,1,0.
REQ-029 The bench SHALL cover check mode: ABC = 101, D = 0, chk_en = 1, chk_p = 1 -> err = 1 and err_cnt = 1 on the next cycle; the same with chk_p = 0 -> err = 0 and err_cnt unchanged.
REQ-030 The bench SHALL cover saturation: with ERR_CNT_W = 2, apply 5 mismatches -> err_cnt = 3 thereafter, with err still pulsing on each mismatch.
REQ-031 The bench SHALL cover async reset: assert rst_n = 0 between clock edges while P = 1 and err_cnt = 3 -> P, p_valid, err and err_cnt = 0 immediately.
REQ-032 The bench SHALL cover hold: ABC = 111, D = 0 with in_valid = 1 -> P = 1; then in_valid = 0 with inputs changing -> P stays 1 and p_valid = 0.
